// File: rtl/semafor_pkg.sv
// Shared definitions for the traffic-light phase blocks.
// Contains the state encoding, the default phase timings and the state classification helpers.
package semafor_pkg;

    typedef enum logic [2:0] {
        S_ROSU     = 3'd0,
        S_VERDE    = 3'd1,
        S_GALBEN   = 3'd2,
        S_ROSU_TOT = 3'd3,
        S_DONE     = 3'd4,
        S_SERVICE  = 3'd5
    } stare_t;

    localparam int DEF_CNT_W      = 8;
    localparam int DEF_T_VERDE    = 20;
    localparam int DEF_T_GALBEN   = 4;
    localparam int DEF_T_ROSU_TOT = 2;
    localparam int DEF_T_BLINK    = 8;

    // States whose duration is measured by the down-counter.
    function automatic logic este_temporizat(input stare_t s);
        return (s == S_VERDE) || (s == S_GALBEN) || (s == S_ROSU_TOT);
    endfunction

    function automatic logic aprins_rosu(input stare_t s);
        return (s == S_ROSU) || (s == S_ROSU_TOT) || (s == S_DONE);
    endfunction

endpackage

// File: rtl/num_descrescator.sv
// Loadable down-counter that saturates at zero and exposes a zero flag.
// A load takes priority over a decrement.
module num_descrescator #(
    parameter int CNT_W = 8
) (
    input  logic             clk_i,
    input  logic             reset_n,
    input  logic             load_i,
    input  logic [CNT_W-1:0] val_i,
    input  logic             dec_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             zero_o
);

    localparam logic [CNT_W-1:0] UNU = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - UNU;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/semafor_faza.sv
// One approach of a traffic light: green -> yellow -> all-red clearance -> done, plus service mode.
// Define SEMAFOR_SERVICE_BLINK_EN to make the yellow lamp blink in service mode (steady otherwise).
module semafor_faza
    import semafor_pkg::*;
#(
    parameter int CNT_W      = DEF_CNT_W,
    parameter int T_VERDE    = DEF_T_VERDE,
    parameter int T_GALBEN   = DEF_T_GALBEN,
    parameter int T_ROSU_TOT = DEF_T_ROSU_TOT,
    parameter int T_BLINK    = DEF_T_BLINK
) (
    input  logic             clk_i,
    input  logic             reset_n,
    input  logic             enable_i,
    input  logic             clear_i,
    input  logic             service_i,
    output logic             verde_o,
    output logic             galben_o,
    output logic             rosu_o,
    output logic             done_o,
    output logic [CNT_W-1:0] timp_o
);

    localparam logic [CNT_W-1:0] LD_VERDE    = CNT_W'(T_VERDE - 1);
    localparam logic [CNT_W-1:0] LD_GALBEN   = CNT_W'(T_GALBEN - 1);
    localparam logic [CNT_W-1:0] LD_ROSU_TOT = CNT_W'(T_ROSU_TOT - 1);
    localparam logic [CNT_W-1:0] LD_BLINK    = CNT_W'(T_BLINK - 1);

    stare_t           stare_q, stare_d;
    logic             cnt_load, cnt_dec, cnt_zero;
    logic [CNT_W-1:0] cnt_val, cnt;
    logic             svc_galben;

`ifdef SEMAFOR_SERVICE_BLINK_EN
    logic blink_q, blink_d;

    always_ff @(posedge clk_i or negedge reset_n) begin
        if (!reset_n) begin
            blink_q <= 1'b0;
        end else begin
            blink_q <= blink_d;
        end
    end

    assign svc_galben = blink_q;
`else
    assign svc_galben = 1'b1;
`endif

    num_descrescator #(
        .CNT_W(CNT_W)
    ) u_cnt (
        .clk_i  (clk_i),
        .reset_n(reset_n),
        .load_i (cnt_load),
        .val_i  (cnt_val),
        .dec_i  (cnt_dec),
        .cnt_o  (cnt),
        .zero_o (cnt_zero)
    );

    always_ff @(posedge clk_i or negedge reset_n) begin
        if (!reset_n) begin
            stare_q <= S_ROSU;
        end else begin
            stare_q <= stare_d;
        end
    end

    always_comb begin
        stare_d  = stare_q;
        cnt_load = 1'b0;
        cnt_val  = '0;
        cnt_dec  = 1'b0;
`ifdef SEMAFOR_SERVICE_BLINK_EN
        blink_d  = blink_q;
`endif
        // Service overrides everything; while it stays asserted the counter paces the blink.
        if (service_i) begin
            if (stare_q != S_SERVICE) begin
                stare_d  = S_SERVICE;
                cnt_load = 1'b1;
                cnt_val  = LD_BLINK;
`ifdef SEMAFOR_SERVICE_BLINK_EN
                blink_d  = 1'b1;
`endif
            end else begin
`ifdef SEMAFOR_SERVICE_BLINK_EN
                if (cnt_zero) begin
                    cnt_load = 1'b1;
                    cnt_val  = LD_BLINK;
                    blink_d  = ~blink_q;
                end else begin
                    cnt_dec = 1'b1;
                end
`endif
            end
        end else begin
            unique case (stare_q)
                S_ROSU: begin
                    if (enable_i) begin
                        stare_d  = S_VERDE;
                        cnt_load = 1'b1;
                        cnt_val  = LD_VERDE;
                    end
                end
                S_VERDE: begin
                    if (cnt_zero) begin
                        stare_d  = S_GALBEN;
                        cnt_load = 1'b1;
                        cnt_val  = LD_GALBEN;
                    end else begin
                        cnt_dec = 1'b1;
                    end
                end
                S_GALBEN: begin
                    if (cnt_zero) begin
                        stare_d  = S_ROSU_TOT;
                        cnt_load = 1'b1;
                        cnt_val  = LD_ROSU_TOT;
                    end else begin
                        cnt_dec = 1'b1;
                    end
                end
                S_ROSU_TOT: begin
                    if (cnt_zero) begin
                        stare_d = S_DONE;
                    end else begin
                        cnt_dec = 1'b1;
                    end
                end
                S_DONE: begin
                    if (clear_i) begin
                        stare_d = S_ROSU;
                    end
                end
                S_SERVICE: begin
                    stare_d  = S_ROSU;
                    cnt_load = 1'b1;
                    cnt_val  = '0;
`ifdef SEMAFOR_SERVICE_BLINK_EN
                    blink_d  = 1'b0;
`endif
                end
                default: begin
                    stare_d  = S_ROSU;
                    cnt_load = 1'b1;
                    cnt_val  = '0;
                end
            endcase
        end
    end

    always_comb begin
        verde_o  = (stare_q == S_VERDE);
        galben_o = (stare_q == S_GALBEN) || ((stare_q == S_SERVICE) && svc_galben);
        rosu_o   = aprins_rosu(stare_q);
        done_o   = (stare_q == S_DONE);
        timp_o   = este_temporizat(stare_q) ? cnt : '0;
    end

endmodule

// File: tb/tb_semafor_faza.sv
// Scoreboard bench for semafor_faza: per-cycle expected lamp/done/timp vectors are queued
// with the stimulus and popped at each falling edge.
`timescale 1ns/1ps
module tb_semafor_faza;

    localparam int CNT_W      = 8;
    localparam int T_VERDE    = 5;
    localparam int T_GALBEN   = 2;
    localparam int T_ROSU_TOT = 1;
    localparam int T_BLINK    = 3;
    localparam int VW         = CNT_W + 4;

    typedef logic [VW-1:0] vec_t;

`ifdef SEMAFOR_SERVICE_BLINK_EN
    localparam logic [0:6] SVC_G = 7'b1110001;
`else
    localparam logic [0:6] SVC_G = 7'b1111111;
`endif

    logic             clk_i     = 1'b0;
    logic             reset_n   = 1'b0;
    logic             enable_i  = 1'b0;
    logic             clear_i   = 1'b0;
    logic             service_i = 1'b0;
    logic             verde_o, galben_o, rosu_o, done_o;
    logic [CNT_W-1:0] timp_o;
    vec_t             obs_w;
    vec_t             expv;
    vec_t             sb[$];
    int               checks = 0;
    int               errors = 0;

    semafor_faza #(
        .CNT_W     (CNT_W),
        .T_VERDE   (T_VERDE),
        .T_GALBEN  (T_GALBEN),
        .T_ROSU_TOT(T_ROSU_TOT),
        .T_BLINK   (T_BLINK)
    ) dut (
        .clk_i    (clk_i),
        .reset_n  (reset_n),
        .enable_i (enable_i),
        .clear_i  (clear_i),
        .service_i(service_i),
        .verde_o  (verde_o),
        .galben_o (galben_o),
        .rosu_o   (rosu_o),
        .done_o   (done_o),
        .timp_o   (timp_o)
    );

    always #5 clk_i = ~clk_i;

    assign obs_w = {verde_o, galben_o, rosu_o, done_o, timp_o};

    always @(negedge clk_i)
        assert (!(verde_o && galben_o) && ($countones({verde_o, galben_o, rosu_o}) <= 1))
        else $error("FAIL lamp_excl got v=%b g=%b r=%b, want at most one lamp", verde_o, galben_o, rosu_o);

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic vec_t ev(input logic v, input logic g, input logic r, input logic d, input int t);
        vec_t x;
        x = {v, g, r, d, t[CNT_W-1:0]};
        return x;
    endfunction

    task automatic push_phase();
        for (int i = 0; i < T_VERDE; i++)    sb.push_back(ev(1, 0, 0, 0, T_VERDE - 1 - i));
        for (int i = 0; i < T_GALBEN; i++)   sb.push_back(ev(0, 1, 0, 0, T_GALBEN - 1 - i));
        for (int i = 0; i < T_ROSU_TOT; i++) sb.push_back(ev(0, 0, 1, 0, T_ROSU_TOT - 1 - i));
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        sb.push_back(ev(0, 0, 1, 0, 0));
        sb.push_back(ev(0, 0, 1, 0, 0));
        @(negedge clk_i);
        expv = sb.pop_front();
        checks++;
        if (obs_w !== expv) begin
            errors++;
            $display("FAIL reset_state got=%h want=%h (v,g,r,d,timp)", obs_w, expv);
        end
        reset_n = 1'b1;
        @(negedge clk_i);
        expv = sb.pop_front();
        checks++;
        if (obs_w !== expv) begin
            errors++;
            $display("FAIL reset_idle got=%h want=%h (v,g,r,d,timp)", obs_w, expv);
        end
    endtask

    // Full phase, clear pulses during green (ignored), done held 4 cycles, then clear.
    task automatic test_phase_clear();
        push_phase();
        for (int i = 0; i < 4; i++) sb.push_back(ev(0, 0, 1, 1, 0));
        for (int i = 0; i < 3; i++) sb.push_back(ev(0, 0, 1, 0, 0));
        enable_i = 1'b1;
        for (int i = 0; sb.size() > 0; i++) begin
            @(negedge clk_i);
            expv = sb.pop_front();
            checks++;
            if (obs_w !== expv) begin
                errors++;
                $display("FAIL phase_clear[%0d] got=%h want=%h (v,g,r,d,timp)", i, obs_w, expv);
            end
            enable_i = 1'b0;
            clear_i  = (i == 1) || (i == 2) || (i == 11);
        end
        clear_i = 1'b0;
    endtask

    // enable dropped after the 2nd green cycle; clear+enable together in done returns to red only.
    task automatic test_enable_drop();
        push_phase();
        sb.push_back(ev(0, 0, 1, 1, 0));
        sb.push_back(ev(0, 0, 1, 0, 0));
        sb.push_back(ev(0, 0, 1, 0, 0));
        enable_i = 1'b1;
        for (int i = 0; sb.size() > 0; i++) begin
            @(negedge clk_i);
            expv = sb.pop_front();
            checks++;
            if (obs_w !== expv) begin
                errors++;
                $display("FAIL enable_drop[%0d] got=%h want=%h (v,g,r,d,timp)", i, obs_w, expv);
            end
            enable_i = (i < 1) || (i == 8);
            clear_i  = (i == 8);
        end
        enable_i = 1'b0;
        clear_i  = 1'b0;
    endtask

    // Service requested during the first yellow cycle, held 7 cycles, then released.
    task automatic test_service();
        for (int i = 0; i < T_VERDE; i++) sb.push_back(ev(1, 0, 0, 0, T_VERDE - 1 - i));
        sb.push_back(ev(0, 1, 0, 0, T_GALBEN - 1));
        for (int j = 0; j < 7; j++) sb.push_back(ev(0, SVC_G[j], 0, 0, 0));
        sb.push_back(ev(0, 0, 1, 0, 0));
        sb.push_back(ev(0, 0, 1, 0, 0));
        enable_i = 1'b1;
        for (int i = 0; sb.size() > 0; i++) begin
            @(negedge clk_i);
            expv = sb.pop_front();
            checks++;
            if (obs_w !== expv) begin
                errors++;
                $display("FAIL service[%0d] got=%h want=%h (v,g,r,d,timp)", i, obs_w, expv);
            end
            enable_i  = 1'b0;
            service_i = (i >= 5) && (i < 12);
        end
        service_i = 1'b0;
    endtask

    // Reset pulled low mid-green between clock edges; lamps must react without an edge.
    task automatic test_async_reset();
        sb.push_back(ev(1, 0, 0, 0, T_VERDE - 1));
        sb.push_back(ev(1, 0, 0, 0, T_VERDE - 2));
        sb.push_back(ev(0, 0, 1, 0, 0));
        sb.push_back(ev(0, 0, 1, 0, 0));
        sb.push_back(ev(0, 0, 1, 0, 0));
        sb.push_back(ev(1, 0, 0, 0, T_VERDE - 1));
        enable_i = 1'b1;
        @(negedge clk_i);
        expv = sb.pop_front();
        checks++;
        if (obs_w !== expv) begin
            errors++;
            $display("FAIL arst_green0 got=%h want=%h (v,g,r,d,timp)", obs_w, expv);
        end
        enable_i = 1'b0;
        @(negedge clk_i);
        expv = sb.pop_front();
        checks++;
        if (obs_w !== expv) begin
            errors++;
            $display("FAIL arst_green1 got=%h want=%h (v,g,r,d,timp)", obs_w, expv);
        end
        #2 reset_n = 1'b0;
        #1;
        expv = sb.pop_front();
        checks++;
        if (obs_w !== expv) begin
            errors++;
            $display("FAIL arst_async got=%h want=%h (v,g,r,d,timp)", obs_w, expv);
        end
        @(negedge clk_i);
        expv = sb.pop_front();
        checks++;
        if (obs_w !== expv) begin
            errors++;
            $display("FAIL arst_held got=%h want=%h (v,g,r,d,timp)", obs_w, expv);
        end
        reset_n = 1'b1;
        @(negedge clk_i);
        expv = sb.pop_front();
        checks++;
        if (obs_w !== expv) begin
            errors++;
            $display("FAIL arst_idle got=%h want=%h (v,g,r,d,timp)", obs_w, expv);
        end
        enable_i = 1'b1;
        @(negedge clk_i);
        expv = sb.pop_front();
        checks++;
        if (obs_w !== expv) begin
            errors++;
            $display("FAIL arst_restart got=%h want=%h (v,g,r,d,timp)", obs_w, expv);
        end
        enable_i = 1'b0;
    endtask

    initial begin
        test_reset();
        test_phase_clear();
        test_enable_drop();
        test_service();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
